// File: rtl/ex_mem_buffer_if.sv
// EX->MEM stream bundle: EX-side entry with handshake, MEM-side head entry with handshake.
// The buffer sits on the slave modport; the surrounding pipeline drives the master modport.
`timescale 1ns/1ps
interface ex_mem_buffer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic              in_of;
  logic [2:0]        in_alu_sel;
  logic [REG_W-1:0]  in_rd;
  logic              in_reg_we;
  logic              in_mem_re;
  logic              in_mem_we;
  logic [DATA_W-1:0] in_sdata;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [REG_W-1:0]  out_rd;
  logic              out_reg_we;
  logic              out_mem_re;
  logic              out_mem_we;
  logic [DATA_W-1:0] out_sdata;

  modport master (
    output in_valid, in_result, in_of, in_alu_sel, in_rd, in_reg_we, in_mem_re, in_mem_we,
           in_sdata, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_reg_we, out_mem_re, out_mem_we,
           out_sdata
  );

  modport slave (
    input  in_valid, in_result, in_of, in_alu_sel, in_rd, in_reg_we, in_mem_re, in_mem_we,
           in_sdata, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_reg_we, out_mem_re, out_mem_we,
           out_sdata
  );
endinterface

// File: rtl/ex_mem_buffer.sv
// Two-entry elastic buffer between EX and MEM: head/skid registers, overflow trap
// qualification of reg writes, sticky overflow flag and saturating trap counter.
`timescale 1ns/1ps
module ex_mem_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              of_trap_en,
  input  logic              of_clr,
  ex_mem_buffer_if.slave    bus,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic              of_flag,
  output logic [7:0]        of_count
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [REG_W-1:0]  rd;
    logic              reg_we;
    logic              mem_re;
    logic              mem_we;
    logic [DATA_W-1:0] sdata;
  } entry_t;

  state_e     state_q, state_d;
  entry_t     head_q, skid_q, in_entry;
  logic       in_ready_q;
  logic       of_flag_q;
  logic [7:0] of_count_q;
  logic       push, pop, ovf, trap;

  // A flushed push is dropped entirely, including its trap side effects.
  assign push = bus.in_valid & in_ready_q & ~flush;
  assign pop  = bus.out_valid & bus.out_ready;
  assign ovf  = bus.in_of & ((bus.in_alu_sel == 3'b010) | (bus.in_alu_sel == 3'b110));
  assign trap = push & ovf & of_trap_en;

  always_comb begin
    in_entry.result = bus.in_result;
    in_entry.rd     = bus.in_rd;
    in_entry.reg_we = bus.in_reg_we & ~(ovf & of_trap_en);
    in_entry.mem_re = bus.in_mem_re;
    in_entry.mem_we = bus.in_mem_we;
    in_entry.sdata  = bus.in_sdata;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: if (push) state_d = StOne;
        StOne: begin
          if (push && !pop)      state_d = StTwo;
          else if (!push && pop) state_d = StEmpty;
        end
        StTwo:   if (pop) state_d = StOne;
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b0;
      head_q     <= '0;
      skid_q     <= '0;
      of_flag_q  <= 1'b0;
      of_count_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      // Registered ready keeps out_ready off any combinational path to in_ready.
      in_ready_q <= (state_d != StTwo);

      case (state_q)
        StEmpty: if (push) head_q <= in_entry;
        StOne: begin
          if (push && pop)  head_q <= in_entry;
          else if (push)    skid_q <= in_entry;
        end
        StTwo:   if (pop) head_q <= skid_q;
        default: ;
      endcase

      if (trap) begin
        of_flag_q  <= 1'b1;
        of_count_q <= of_clr ? 8'h01 : ((of_count_q == 8'hFF) ? 8'hFF : of_count_q + 8'h01);
      end else if (of_clr) begin
        of_flag_q  <= 1'b0;
        of_count_q <= 8'h00;
      end
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = (state_q != StEmpty);
  assign bus.out_result = head_q.result;
  assign bus.out_rd     = head_q.rd;
  assign bus.out_reg_we = head_q.reg_we;
  assign bus.out_mem_re = head_q.mem_re;
  assign bus.out_mem_we = head_q.mem_we;
  assign bus.out_sdata  = head_q.sdata;

  assign fwd_valid = bus.out_valid & head_q.reg_we & (head_q.rd != '0);
  assign fwd_rd    = head_q.rd;
  assign fwd_data  = head_q.result;
  assign of_flag   = of_flag_q;
  assign of_count  = of_count_q;

endmodule
